// File: rtl/bloom_client_arbiter.sv
// bloom_client_arbiter
//   Shares one Bloom filter engine among N clients. Grants round-robin from a
//   rotating pointer, fires a one-cycle insert/query pulse, follows the
//   engine's busy flag, and returns the sticky match result to the granted
//   client. A watchdog turns a hung engine into an error response.
// Ports
//   clk, rst              clock, async active-high reset
//   req_valid/op/data     per-client request channel (op: 0 insert, 1 query)
//   req_ready             per-client accept, one-hot or zero (combinational)
//   rsp_valid/rsp_ready   per-client response handshake
//   rsp_match, rsp_err    shared response payload, qualified by rsp_valid
//   fe_insert/query/data  command to the engine
//   fe_busy, fe_match     status from the engine
module bloom_client_arbiter #(
  parameter int N       = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N-1:0]        req_op,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ready,
  output logic [N-1:0]        rsp_valid,
  input  logic [N-1:0]        rsp_ready,
  output logic                rsp_match,
  output logic                rsp_err,
  output logic                fe_insert,
  output logic                fe_query,
  output logic [DATA_W-1:0]   fe_data,
  input  logic                fe_busy,
  input  logic                fe_match
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WBUSY = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]              state;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           g;
  logic                    op;
  logic [DATA_W-1:0]       data;
  logic                    mbit;
  logic                    err;
  logic [CW-1:0]           cnt;

  logic [N-1:0][DATA_W-1:0] req_data_v;
  logic                     gnt_any;
  logic [IW-1:0]            gnt_idx;
  logic                     take;
  logic                     wd_hit;

  assign req_data_v = req_data;

  // First valid client at or after the pointer, ascending mod N.
  always_comb begin : grant_sel
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  // A still-busy engine (e.g. from another master) blocks new grants.
  assign take   = (state == S_IDLE) && !fe_busy && gnt_any;
  assign wd_hit = (cnt == CW'(TIMEOUT - 1));

  for (genvar i = 0; i < N; i++) begin : g_client
    assign req_ready[i] = take && (gnt_idx == IW'(i));
    assign rsp_valid[i] = (state == S_RESP) && (g == IW'(i));
  end

  assign fe_insert = (state == S_ISSUE) && !op;
  assign fe_query  = (state == S_ISSUE) &&  op;
  assign fe_data   = (state == S_ISSUE || state == S_WBUSY || state == S_WDONE) ? data : '0;
  assign rsp_match = (state == S_RESP) && mbit && op && !err;
  assign rsp_err   = (state == S_RESP) && err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      g     <= '0;
      op    <= 1'b0;
      data  <= '0;
      mbit  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (take) begin
          g     <= gnt_idx;
          op    <= req_op[gnt_idx];
          data  <= req_data_v[gnt_idx];
          mbit  <= 1'b0;
          err   <= 1'b0;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WBUSY;
        end
        // Normal progress wins over the watchdog on the same cycle.
        S_WBUSY: begin
          mbit <= mbit | fe_match;
          if (fe_busy) begin
            cnt   <= '0;
            state <= S_WDONE;
          end else if (wd_hit) begin
            err   <= 1'b1;
            mbit  <= 1'b0;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WDONE: begin
          mbit <= mbit | fe_match;
          if (!fe_busy) begin
            state <= S_RESP;
          end else if (wd_hit) begin
            err   <= 1'b1;
            mbit  <= 1'b0;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: if (rsp_ready[g]) begin
          ptr   <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_client_arbiter.sv
// Directed bench for bloom_client_arbiter with a small engine stub:
// busy rises the cycle after a pulse and lasts 2 cycles (insert) or
// 3 cycles (query); match is shown on the last busy cycle of a query hit.
module tb_bloom_client_arbiter;
  localparam int N = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_op, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_data;
  logic          rsp_match, rsp_err, fe_insert, fe_query, fe_busy, fe_match;
  logic [DW-1:0] fe_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bloom_client_arbiter #(.N(N), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_match(rsp_match), .rsp_err(rsp_err),
    .fe_insert(fe_insert), .fe_query(fe_query), .fe_data(fe_data),
    .fe_busy(fe_busy), .fe_match(fe_match)
  );

  // Engine stub
  logic        eng_stuck = 1'b0;
  logic [2:0]  bcnt;
  logic        qhit;
  logic [DW-1:0] stored[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      qhit <= 1'b0;
    end else if (!eng_stuck && fe_insert) begin
      stored.push_back(fe_data);
      bcnt <= 3'd2;
      qhit <= 1'b0;
    end else if (!eng_stuck && fe_query) begin
      qhit <= 1'b0;
      foreach (stored[i]) if (stored[i] == fe_data) qhit <= 1'b1;
      bcnt <= 3'd3;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1'b1;
    end
  end
  assign fe_busy  = (bcnt != 0);
  assign fe_match = qhit && (bcnt == 3'd1);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int c, input logic o, input logic [DW-1:0] d);
    req_valid[c] = 1'b1;
    req_op[c] = o;
    req_data[c*DW +: DW] = d;
  endtask

  function automatic logic [63:0] outs();
    return {24'd0, req_ready, rsp_valid, rsp_match, rsp_err, fe_insert, fe_query};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic multihot;
    logic saw_rsp;
    rst = 1'b1; req_valid = '0; req_op = '0; req_data = '0; rsp_ready = '0;
    step(3);
    chk("reset_outs", outs(), 64'd0);
    chk("reset_fe_data", fe_data, 0);
    rst = 1'b0;
    rsp_ready = 4'hF;

    // client 0 inserts 0x1234
    set_req(0, 1'b0, 32'h0000_1234); #1;
    chk("ins_ready", req_ready, 4'b0001);
    step(); req_valid[0] = 1'b0;
    chk("ins_pulse", {fe_insert, fe_query}, 2'b10);
    chk("ins_fe_data", fe_data, 32'h1234);
    step();
    chk("ins_pulse_gone", {fe_insert, fe_query}, 2'b00);
    chk("ins_data_held", fe_data, 32'h1234);
    step(2);
    chk("ins_rsp_early", rsp_valid, 4'b0000);
    step();
    chk("ins_rsp_c5", {rsp_valid, rsp_match, rsp_err}, {4'b0001, 1'b0, 1'b0});
    step();
    chk("ins_rsp_done", rsp_valid, 4'b0000);

    // client 2 queries 0x1234 (hit), pointer now 1
    set_req(2, 1'b1, 32'h0000_1234); #1;
    chk("qh_ready", req_ready, 4'b0100);
    step(); req_valid[2] = 1'b0;
    chk("qh_pulse", {fe_insert, fe_query}, 2'b01);
    step(4);
    chk("qh_rsp_early", rsp_valid, 4'b0000);
    step();
    chk("qh_rsp_c6", {rsp_valid, rsp_match, rsp_err}, {4'b0100, 1'b1, 1'b0});
    step();

    // client 2 queries 0x9999 (miss), pointer now 3 and wraps to 2
    set_req(2, 1'b1, 32'h0000_9999); #1;
    chk("qm_ready", req_ready, 4'b0100);
    step(); req_valid[2] = 1'b0;
    step(5);
    chk("qm_rsp_c6", {rsp_valid, rsp_match, rsp_err}, {4'b0100, 1'b0, 1'b0});
    step();

    // response stall: client 3 query hit with only non-granted rsp_ready high,
    // client 0 waiting the whole time
    rsp_ready = 4'b0111;
    set_req(3, 1'b1, 32'h0000_1234);
    set_req(0, 1'b0, 32'h0000_AAAA); #1;
    chk("st_ready", req_ready, 4'b1000);
    step(); req_valid[3] = 1'b0;
    step(5);
    for (int k = 0; k < 10; k++) begin
      chk("st_hold", {req_ready, rsp_valid, rsp_match, rsp_err}, {4'b0000, 4'b1000, 1'b1, 1'b0});
      step();
    end
    rsp_ready = 4'hF; #1;
    chk("st_release_same", {req_ready, rsp_valid}, {4'b0000, 4'b1000});
    step();
    chk("st_next_grant", req_ready, 4'b0001);
    step(); req_valid[0] = 1'b0;
    step(4);
    chk("c0_rsp", {rsp_valid, rsp_match, rsp_err}, {4'b0001, 1'b0, 1'b0});
    step();

    // watchdog: engine ignores the pulse, client 1 query
    eng_stuck = 1'b1;
    set_req(1, 1'b1, 32'h0000_5555); #1;
    chk("wd_ready", req_ready, 4'b0010);
    step(); req_valid[1] = 1'b0;
    chk("wd_pulse", fe_query, 1'b1);
    step(16);
    chk("wd_c17", {rsp_valid, fe_data}, {4'b0000, 32'h5555});
    step();
    chk("wd_c18", {rsp_valid, rsp_match, rsp_err}, {4'b0010, 1'b0, 1'b1});
    step();
    eng_stuck = 1'b0;

    // next request served normally: client 2 query 0xAAAA (inserted earlier)
    set_req(2, 1'b1, 32'h0000_AAAA); #1;
    chk("post_wd_ready", req_ready, 4'b0100);
    step(); req_valid[2] = 1'b0;
    step(5);
    chk("post_wd_rsp", {rsp_valid, rsp_match, rsp_err}, {4'b0100, 1'b1, 1'b0});
    step();

    // reset during WAIT_DONE: client 3 query
    set_req(3, 1'b1, 32'h0000_1234); #1;
    chk("rst_ready", req_ready, 4'b1000);
    step(); req_valid[3] = 1'b0;
    step(2);
    chk("rst_pre_data", fe_data, 32'h1234);
    rst = 1'b1; #1;
    chk("rst_mid_outs", outs(), 64'd0);
    chk("rst_mid_data", fe_data, 0);
    step(2);
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid != 0) saw_rsp = 1'b1;
      step();
    end
    chk("rst_no_rsp", saw_rsp, 1'b0);

    // all clients request continuously: grants 0,1,2,3,0
    multihot = 1'b0;
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 32'h100 * c + 7);
    #1;
    for (int s = 0; s < 5; s++) begin
      for (int w = 0; w < 40 && req_ready == 0; w++) begin
        if ($countones(rsp_valid) > 1) multihot = 1'b1;
        step();
      end
      if ($countones(req_ready) > 1) multihot = 1'b1;
      chk($sformatf("rr_grant%0d", s), req_ready, 4'b0001 << (s % N));
      step();
    end
    req_valid = '0;
    for (int w = 0; w < 40 && rsp_valid == 0; w++) step();
    chk("rr_last_rsp", rsp_valid, 4'b0001);
    step();
    chk("rr_onehot", multihot, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
